// File: rtl/inst_rom_responder_if.sv
// Fetch-port bundle between the IF stage (master) and the instruction ROM responder (slave).
interface inst_rom_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    rom_en;
    logic [DATA_WIDTH/8-1:0] rom_write_en;
    logic [ADDR_WIDTH-1:0]   rom_addr;
    logic [DATA_WIDTH-1:0]   rom_write_data;
    logic [DATA_WIDTH-1:0]   rom_read_data;
    logic                    rom_rvalid;
    logic                    rom_addr_err;
    logic [31:0]             rom_fetch_cnt;

    modport master (
        output rom_en, rom_write_en, rom_addr, rom_write_data,
        input  rom_read_data, rom_rvalid, rom_addr_err, rom_fetch_cnt
    );

    modport slave (
        input  rom_en, rom_write_en, rom_addr, rom_write_data,
        output rom_read_data, rom_rvalid, rom_addr_err, rom_fetch_cnt
    );
endinterface

// File: rtl/inst_rom_responder.sv
// Instruction memory responder: kseg fold + base decode, read-first byte-lane writes, 1-cycle read latency.
// Optional macro INST_ROM_ALIGN_CHECK_EN turns non-word-aligned fetch addresses into address errors.
module inst_rom_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_PADDR = 32'h1fc00000
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_rom_responder_if.slave  rom
);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [ADDR_WIDTH-1:0] SEG_MASK = ADDR_WIDTH'(32'h1fffffff);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] paddr;
    logic [ADDR_WIDTH-1:0] off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_range;
    logic                  misaligned;
    logic                  addr_ok;
    logic                  is_read;
    logic                  unused_off_lo;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    logic                  err_q;
    logic [31:0]           fetch_cnt_q;

    // Offset is modulo 2^ADDR_WIDTH, so addresses below the base wrap large and fail the range test.
    always_comb begin
        paddr    = rom.rom_addr & SEG_MASK;
        off      = paddr - BASE_PADDR;
        idx      = off[DEPTH_LOG2+1:2];
        in_range = (paddr >= BASE_PADDR) && (off[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);
`ifdef INST_ROM_ALIGN_CHECK_EN
        misaligned = (rom.rom_addr[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        addr_ok = in_range && !misaligned;
        is_read = rom.rom_en && (rom.rom_write_en == '0) && !misaligned;
    end

    // Byte offset inside the word never selects data; the containing word is always accessed.
    assign unused_off_lo = &{1'b0, off[1:0]};

    // Response path; out-of-range reads still count as accepted fetches.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            rvalid_q <= rom.rom_en;
            err_q    <= rom.rom_en && !addr_ok;
            if (rom.rom_en)
                rdata_q <= addr_ok ? mem[idx] : '0;
            if (is_read && (fetch_cnt_q != '1))
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    // Memory array has no reset so it maps onto block RAM; the read above sees pre-write data.
    always_ff @(posedge clk) begin
        if (!rst && rom.rom_en && addr_ok) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (rom.rom_write_en[i])
                    mem[idx][8*i +: 8] <= rom.rom_write_data[8*i +: 8];
            end
        end
    end

    assign rom.rom_read_data = rdata_q;
    assign rom.rom_rvalid    = rvalid_q;
    assign rom.rom_addr_err  = err_q;
    assign rom.rom_fetch_cnt = fetch_cnt_q;
endmodule

// File: tb/tb_inst_rom_responder.sv
// Randomized bench for inst_rom_responder against a word-array reference model.
module tb_inst_rom_responder;
    localparam int          DEPTH_LOG2 = 12;
    localparam int          DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [31:0] BASE       = 32'h1fc00000;
    localparam logic [31:0] WORD0      = 32'h3c08bfc0;
    localparam logic [31:0] WORD1      = 32'h25080010;
`ifdef INST_ROM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_rom_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) rom_if ();

    inst_rom_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2), .BASE_PADDR(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rom(rom_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mmem   [DEPTH];
    bit          mknown [DEPTH];
    logic [31:0] m_cnt      = '0;
    logic [31:0] exp_rdata  = '0;
    bit          exp_known  = 1'b1;
    logic        exp_rvalid = 1'b0;
    logic        exp_err    = 1'b0;
    bit          chk_en     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Compare process: every cycle, one time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("rvalid", {31'd0, rom_if.rom_rvalid}, {31'd0, exp_rvalid});
            chk("addr_err", {31'd0, rom_if.rom_addr_err}, {31'd0, exp_err});
            chk("fetch_cnt", rom_if.rom_fetch_cnt, m_cnt);
            if (exp_known)
                chk("read_data", rom_if.rom_read_data, exp_rdata);
        end
    end

    // Drive one cycle and compute what the outputs must be after the next rising edge.
    task automatic step(input bit r, input bit en, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] pa;
        int unsigned word;
        bit ok, mis;
        @(negedge clk);
        rst                   = r;
        rom_if.rom_en         = en;
        rom_if.rom_write_en   = we;
        rom_if.rom_addr       = addr;
        rom_if.rom_write_data = wd;
        if (r) begin
            exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = '0; exp_known = 1'b1; m_cnt = '0;
        end else if (en) begin
            pa   = addr & 32'h1fffffff;
            mis  = ALIGN_CHK && (addr[1:0] != 2'b00);
            ok   = !mis && (pa >= BASE) && ((pa - BASE) < 32'(4 * DEPTH));
            word = (pa - BASE) / 4;
            exp_rvalid = 1'b1;
            exp_err    = !ok;
            if (ok) begin
                exp_rdata = mmem[word];
                exp_known = mknown[word];
                for (int i = 0; i < 4; i++)
                    if (we[i]) mmem[word][8*i +: 8] = wd[8*i +: 8];
                if (we == 4'hf) mknown[word] = 1'b1;
            end else begin
                exp_rdata = '0;
                exp_known = 1'b1;
            end
            if (we == 4'h0 && !mis && m_cnt != 32'hffffffff)
                m_cnt = m_cnt + 1;
        end else begin
            exp_rvalid = 1'b0;
            exp_err    = 1'b0;
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        logic [31:0] w;
        w = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, DEPTH - 1));
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: begin
                a = {3'($urandom), 29'(BASE + w * 4)};
                if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom);
            end
            6: a = 32'hbfc03ffc;
            7: a = 32'hbfc04000;
            8: a = 32'hbfbffffc;
            default: a = $urandom;
        endcase
        return a;
    endfunction

    initial begin
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) mknown[i] = 1'b0;
        rom_if.rom_en = 1'b0; rom_if.rom_write_en = '0;
        rom_if.rom_addr = '0; rom_if.rom_write_data = '0;

        // Reset, then idle
        step(1, 0, 4'h0, 32'h0, 32'h0);
        chk_en = 1'b1;
        step(1, 0, 4'h0, 32'h0, 32'h0);
        step(0, 0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("reset_rvalid", {31'd0, rom_if.rom_rvalid}, 32'd0);
        chk("reset_data", rom_if.rom_read_data, 32'd0);
        chk("reset_cnt", rom_if.rom_fetch_cnt, 32'd0);
        step(0, 0, 4'h0, 32'h0, 32'h0);

        // Preload the whole memory through the port
        for (int i = 0; i < DEPTH; i++) begin
            v = (i == 0) ? WORD0 : (i == 1) ? WORD1 : (i == 2) ? 32'h0 : $urandom;
            step(0, 1, 4'hf, 32'hbfc00000 + 32'(4 * i), v);
        end
        step(0, 0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("preload_cnt", rom_if.rom_fetch_cnt, 32'd0);

        // Back-to-back reads
        step(0, 1, 4'h0, 32'hbfc00000, 32'h0);
        settle();
        chk("rd_word0", rom_if.rom_read_data, WORD0);
        step(0, 1, 4'h0, 32'hbfc00004, 32'h0);
        settle();
        chk("rd_word1", rom_if.rom_read_data, WORD1);
        chk("rd_cnt2", rom_if.rom_fetch_cnt, 32'd2);

        // Partial-lane write then read
        step(0, 1, 4'b0101, 32'h9fc00008, 32'haabbccdd);
        settle();
        chk("wr_old_data", rom_if.rom_read_data, 32'h0);
        step(0, 1, 4'h0, 32'hbfc00008, 32'h0);
        settle();
        chk("wr_lanes", rom_if.rom_read_data, 32'h00bb00dd);

        // Out of range
        step(0, 1, 4'h0, 32'hbfc04000, 32'h0);
        settle();
        chk("oor_top_err", {31'd0, rom_if.rom_addr_err}, 32'd1);
        chk("oor_top_data", rom_if.rom_read_data, 32'h0);
        step(0, 1, 4'h0, 32'h80000000, 32'h0);
        settle();
        chk("oor_low_err", {31'd0, rom_if.rom_addr_err}, 32'd1);
        chk("oor_low_valid", {31'd0, rom_if.rom_rvalid}, 32'd1);
        step(0, 1, 4'hf, 32'hbfc04000, 32'hffffffff);
        step(0, 1, 4'h0, 32'hbfc00000, 32'h0);
        step(0, 1, 4'h0, 32'hbfc03ffc, 32'h0);
        step(0, 0, 4'h0, 32'h0, 32'h0);

        // Misaligned fetch
        step(0, 1, 4'h0, 32'hbfc00002, 32'h0);
        settle();
`ifdef INST_ROM_ALIGN_CHECK_EN
        chk("mis_err", {31'd0, rom_if.rom_addr_err}, 32'd1);
        chk("mis_data", rom_if.rom_read_data, 32'h0);
`else
        chk("mis_err", {31'd0, rom_if.rom_addr_err}, 32'd0);
        chk("mis_data", rom_if.rom_read_data, WORD0);
`endif

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'h0,
                 rand_addr(), $urandom);
        end

        // Reset with a read in flight
        step(1, 1, 4'h0, 32'hbfc00000, 32'h0);
        settle();
        chk("rst_flight_valid", {31'd0, rom_if.rom_rvalid}, 32'd0);
        chk("rst_flight_cnt", rom_if.rom_fetch_cnt, 32'd0);

        // Counter saturation
        step(0, 0, 4'h0, 32'h0, 32'h0);
        force dut.fetch_cnt_q = 32'hffffffff;
        m_cnt = 32'hffffffff;
        #1;
        release dut.fetch_cnt_q;
        for (int n = 0; n < 3; n++) step(0, 1, 4'h0, 32'hbfc00004, 32'h0);
        settle();
        chk("cnt_saturate", rom_if.rom_fetch_cnt, 32'hffffffff);
        step(0, 0, 4'h0, 32'h0, 32'h0);
        settle();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
